// File: rtl/leitor_tabuleiro.sv
// leitor_tabuleiro: 8x8 reed-switch scanner with debounced snapshots and move reporting (optional removal report via LEITOR_REMOCAO_EN)
module leitor_tabuleiro #(
  parameter int SETTLE = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [7:0] colunas,
  output logic [7:0] linha_sel,
  output logic [3:0] jogadaLinha,
  output logic [3:0] jogadaColuna,
  output logic       jogou,
  output logic       multipla,
`ifdef LEITOR_REMOCAO_EN
  output logic       removeu,
`endif
  output logic       pronto
);
  localparam logic [1:0] VARRE = 2'd0;
  localparam logic [1:0] AVALIA = 2'd1;
  localparam logic [1:0] REPORTA = 2'd2;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int STW = $clog2(DEBOUNCE + 1);
  logic [1:0] state;
  logic [2:0] r;
  logic [SW-1:0] settle;
  logic [STW-1:0] stab, stab_n;
  logic [63:0] scan, last_scan, accepted, novo, sel;
  logic [5:0] idx;
  logic accept;
`ifdef LEITOR_REMOCAO_EN
  logic [63:0] vago;
`endif
  assign linha_sel = 8'd1 << r;
  assign stab_n = (scan == last_scan) ? ((stab == STW'(DEBOUNCE)) ? stab : stab + 1'b1) : STW'(1);
  assign accept = stab_n == STW'(DEBOUNCE);
  // new/vacated squares and the lowest index among those to be reported
  always_comb begin
    novo = scan & ~accepted;
`ifdef LEITOR_REMOCAO_EN
    vago = accepted & ~scan;
    sel = |novo ? novo : vago;
`else
    sel = novo;
`endif
    idx = '0;
    for (int i = 63; i >= 0; i--) if (sel[i]) idx = 6'(i);
  end
  // scan rows, evaluate each full snapshot, and pulse the report for one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= VARRE;
      r <= '0;
      settle <= '0;
      stab <= '0;
      scan <= '0;
      last_scan <= '0;
      accepted <= '0;
      jogadaLinha <= '0;
      jogadaColuna <= '0;
      jogou <= 1'b0;
      multipla <= 1'b0;
      pronto <= 1'b0;
`ifdef LEITOR_REMOCAO_EN
      removeu <= 1'b0;
`endif
    end else begin
      jogou <= 1'b0;
      multipla <= 1'b0;
`ifdef LEITOR_REMOCAO_EN
      removeu <= 1'b0;
`endif
      case (state)
        VARRE: begin
          if (settle == SW'(SETTLE - 1)) begin
            scan[8*r +: 8] <= colunas;
            settle <= '0;
            r <= r + 3'd1;
            if (r == 3'd7) state <= AVALIA;
          end else settle <= settle + 1'b1;
        end
        AVALIA: begin
          stab <= stab_n;
          last_scan <= scan;
          state <= VARRE;
          if (accept && !pronto) begin
            accepted <= scan;
            pronto <= 1'b1;
          end else if (accept && scan != accepted) begin
            accepted <= scan;
            if (habilita && |novo) begin
              jogadaLinha <= {1'b0, idx[5:3]};
              jogadaColuna <= {1'b0, idx[2:0]};
              multipla <= $countones(novo) > 1;
              jogou <= 1'b1;
              state <= REPORTA;
            end
`ifdef LEITOR_REMOCAO_EN
            else if (habilita && |vago) begin
              jogadaLinha <= {1'b0, idx[5:3]};
              jogadaColuna <= {1'b0, idx[2:0]};
              removeu <= 1'b1;
              state <= REPORTA;
            end
`endif
          end
        end
        default: state <= VARRE;
      endcase
    end
  end
endmodule

// File: tb/tb_leitor_tabuleiro.sv
// tb_leitor_tabuleiro: directed checks of baseline, placement, debounce, disable, removal and reset
module tb_leitor_tabuleiro;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic habilita = 1'b1;
  logic [7:0] colunas, linha_sel;
  logic [3:0] jogadaLinha, jogadaColuna;
  logic jogou, multipla, pronto;
`ifdef LEITOR_REMOCAO_EN
  logic removeu;
`endif
  logic [63:0] board = '0;
  int tests = 0;
  int fails = 0;
  int jog_cnt = 0;
  int rem_cnt = 0;
  int j0, r0;
  logic [3:0] cap_l = '0, cap_c = '0;
  logic cap_m = 1'b0;

  leitor_tabuleiro #(.SETTLE(2), .DEBOUNCE(2)) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .colunas(colunas),
    .linha_sel(linha_sel),
    .jogadaLinha(jogadaLinha),
    .jogadaColuna(jogadaColuna),
    .jogou(jogou),
    .multipla(multipla),
`ifdef LEITOR_REMOCAO_EN
    .removeu(removeu),
`endif
    .pronto(pronto)
  );

  always #5 clock = ~clock;

  // the board model answers whichever row is driven
  always_comb begin
    colunas = '0;
    for (int r = 0; r < 8; r++) if (linha_sel[r]) colunas = board[8*r +: 8];
  end

  // count every cycle that jogou/removeu is high and capture the reported square
  always @(negedge clock) begin
    if (jogou) begin
      jog_cnt <= jog_cnt + 1;
      cap_l <= jogadaLinha;
      cap_c <= jogadaColuna;
      cap_m <= multipla;
    end
`ifdef LEITOR_REMOCAO_EN
    if (removeu) rem_cnt <= rem_cnt + 1;
`endif
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_scan;
    logic [7:0] p;
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      p = linha_sel;
      tick();
      if (p == 8'h80 && linha_sel == 8'h01) done = 1;
    end
    if (!done) begin
      fails++;
      $error("FAIL scan_timeout: got no scan end expected one within 100 cycles");
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_linha_sel", linha_sel, 8'h01);
    chk("rst_jl", jogadaLinha, 0);
    chk("rst_jc", jogadaColuna, 0);
    chk("rst_jogou", jogou, 0);
    chk("rst_multipla", multipla, 0);
    chk("rst_pronto", pronto, 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("walk_row1", linha_sel, 8'h02);
    repeat (13) tick();
    chk("walk_row7", linha_sel, 8'h80);
    tick();
    chk("walk_avalia", linha_sel, 8'h01);
    repeat (17) tick();
    chk("pronto_c33", pronto, 0);
    tick();
    chk("pronto_c34", pronto, 1);
    chk("base_no_jogou", jog_cnt, 0);

    j0 = jog_cnt;
    board[8*3+5] = 1'b1;
    repeat (4) next_scan();
    chk("single_cnt", jog_cnt - j0, 1);
    chk("single_l", cap_l, 3);
    chk("single_c", cap_c, 5);
    chk("single_m", cap_m, 0);
    next_scan();
    chk("hold_l", jogadaLinha, 3);
    chk("hold_c", jogadaColuna, 5);

    j0 = jog_cnt;
    for (int k = 0; k < 6; k++) begin
      board[8*6+2] = ~board[8*6+2];
      next_scan();
    end
    next_scan();
    chk("bounce_none", jog_cnt - j0, 0);
    board[8*6+2] = 1'b1;
    repeat (4) next_scan();
    chk("bounce_once", jog_cnt - j0, 1);
    chk("bounce_l", cap_l, 6);
    chk("bounce_c", cap_c, 2);

    j0 = jog_cnt;
    board[8*1+7] = 1'b1;
    board[8*4+0] = 1'b1;
    repeat (4) next_scan();
    chk("multi_cnt", jog_cnt - j0, 1);
    chk("multi_l", cap_l, 1);
    chk("multi_c", cap_c, 7);
    chk("multi_m", cap_m, 1);

    j0 = jog_cnt;
    habilita = 1'b0;
    board[8*2+2] = 1'b1;
    repeat (4) next_scan();
    chk("disabled_none", jog_cnt - j0, 0);
    habilita = 1'b1;
    repeat (4) next_scan();
    chk("reenabled_none", jog_cnt - j0, 0);

    r0 = rem_cnt;
    board[8*3+5] = 1'b0;
    repeat (4) next_scan();
    chk("remove_no_jogou", jog_cnt - j0, 0);
`ifdef LEITOR_REMOCAO_EN
    chk("remove_pulse", rem_cnt - r0, 1);
    chk("remove_l", jogadaLinha, 3);
    chk("remove_c", jogadaColuna, 5);
`else
    chk("remove_hold_l", jogadaLinha, 1);
    chk("remove_hold_c", jogadaColuna, 7);
`endif

    for (int n = 0; n < 40 && linha_sel != 8'h10; n++) tick();
    chk("reach_row4", linha_sel, 8'h10);
    reset = 1'b1;
    tick();
    chk("midrst_linha_sel", linha_sel, 8'h01);
    chk("midrst_pronto", pronto, 0);
    chk("midrst_jl", jogadaLinha, 0);
    chk("midrst_jc", jogadaColuna, 0);
    chk("midrst_jogou", jogou, 0);
    chk("midrst_multipla", multipla, 0);
    reset = 1'b0;
    j0 = jog_cnt;
    repeat (33) tick();
    chk("rebase_c33", pronto, 0);
    tick();
    chk("rebase_c34", pronto, 1);
    repeat (3) next_scan();
    chk("rebase_no_jogou", jog_cnt - j0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
